// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data port arbiter for the single-ported unified memory (optional stats: ARB_STATS_EN)
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef ARB_STATS_EN
    output logic [15:0]       stat_if_gnts,
    output logic [15:0]       stat_dm_gnts,
    output logic [15:0]       stat_conflicts,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

    localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic [3:0]          starve_cnt_q, starve_cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                arb_point;
    logic                if_win;
    logic                dm_win;
`ifdef ARB_STATS_EN
    logic [15:0]         stat_if_q, stat_if_d;
    logic [15:0]         stat_dm_q, stat_dm_d;
    logic [15:0]         stat_cf_q, stat_cf_d;
`endif

    // Arbitration decision: data port first, fetch wins once its starvation count hits the limit
    always_comb begin
        arb_point = (state_q == S_IDLE) || (state_q == S_RESP);
        if_win    = if_req && (!dm_req || (starve_cnt_q == STARVE_LIM));
        dm_win    = dm_req && !if_win;
    end

    // Next-state logic: transaction sequencing, request capture, response capture, starvation tracking
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        wait_cnt_d   = wait_cnt_q;
        starve_cnt_d = starve_cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
`ifdef ARB_STATS_EN
        stat_if_d    = stat_if_q;
        stat_dm_d    = stat_dm_q;
        stat_cf_d    = stat_cf_q;
`endif
        case (state_q)
            S_IDLE, S_RESP: begin
                if (if_win || dm_win) begin
                    state_d = S_ISSUE;
                    owner_d = if_win ? OWN_IF : OWN_DM;
                    addr_d  = if_win ? if_addr : dm_addr;
                    we_d    = dm_win && dm_we;
                    wdata_d = dm_win ? dm_wdata : '0;
                end else begin
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                end
                // Only a fetch that is actually waiting behind a data grant counts as starved
                if (!if_req || if_win) begin
                    starve_cnt_d = '0;
                end else if (starve_cnt_q < STARVE_LIM) begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end
`ifdef ARB_STATS_EN
                if (if_win && stat_if_q != 16'hFFFF) stat_if_d = stat_if_q + 16'd1;
                if (dm_win && stat_dm_q != 16'hFFFF) stat_dm_d = stat_dm_q + 16'd1;
                if (if_req && dm_req && stat_cf_q != 16'hFFFF) stat_cf_d = stat_cf_q + 16'd1;
`endif
            end
            S_ISSUE: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                if (wait_cnt_q == LAT_LAST) begin
                    state_d    = S_RESP;
                    wait_cnt_d = '0;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                    end else if (owner_q == OWN_DM) begin
                        dm_rdata_d = we_q ? '0 : mem_rdata;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight transaction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_NONE;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

`ifdef ARB_STATS_EN
    // Saturating grant/conflict counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_if_q <= '0;
            stat_dm_q <= '0;
            stat_cf_q <= '0;
        end else begin
            stat_if_q <= stat_if_d;
            stat_dm_q <= stat_dm_d;
            stat_cf_q <= stat_cf_d;
        end
    end

    assign stat_if_gnts   = stat_if_q;
    assign stat_dm_gnts   = stat_dm_q;
    assign stat_conflicts = stat_cf_q;
`endif

    // Outputs decoded from registered state so every strobe is a clean one-cycle pulse
    always_comb begin
        if_gnt    = (state_q == S_ISSUE) && (owner_q == OWN_IF);
        dm_gnt    = (state_q == S_ISSUE) && (owner_q == OWN_DM);
        if_rvalid = (state_q == S_RESP) && (owner_q == OWN_IF);
        dm_rvalid = (state_q == S_RESP) && (owner_q == OWN_DM);
        mem_en    = (state_q == S_ISSUE);
        mem_we    = (state_q == S_ISSUE) && we_q;
        mem_addr  = (state_q == S_ISSUE) ? addr_q : '0;
        mem_wdata = (state_q == S_ISSUE) ? wdata_q : '0;
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
        busy      = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic              if_req;
        logic [ADDR_W-1:0] if_addr;
        logic              dm_req;
        logic              dm_we;
        logic [ADDR_W-1:0] dm_addr;
        logic [DATA_W-1:0] dm_wdata;
        logic              exp_dm;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
`ifdef ARB_STATS_EN
    logic [15:0]       stat_if_gnts;
    logic [15:0]       stat_dm_gnts;
    logic [15:0]       stat_conflicts;
`endif

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
`ifdef ARB_STATS_EN
        .stat_if_gnts(stat_if_gnts), .stat_dm_gnts(stat_dm_gnts), .stat_conflicts(stat_conflicts),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: data read at mem_en appears exactly MEM_LAT cycles later, garbage otherwise
    logic [DATA_W-1:0] mem [1024];
    logic [DATA_W-1:0] pipe_d [MEM_LAT];
    bit                pipe_v [MEM_LAT];
    bit                init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem[10'h005] <= 32'hDEADBEEF;
            mem[10'h020] <= 32'h0BADC0DE;
            mem[10'h021] <= 32'hCAFEF00D;
            init_done <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        pipe_v[0] <= mem_en;
        pipe_d[0] <= mem[mem_addr];
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    assign mem_rdata = pipe_v[MEM_LAT-1] ? pipe_d[MEM_LAT-1] : 32'hBAD0BAD0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_vec(input vec_t v, input int idx);
        int  n;
        bit  got;
        if_req   = v.if_req;
        if_addr  = v.if_addr;
        dm_req   = v.dm_req;
        dm_we    = v.dm_we;
        dm_addr  = v.dm_addr;
        dm_wdata = v.dm_wdata;
        @(negedge clk);
        check($sformatf("v%0d_if_gnt", idx), 32'(if_gnt), 32'(!v.exp_dm));
        check($sformatf("v%0d_dm_gnt", idx), 32'(dm_gnt), 32'(v.exp_dm));
        check($sformatf("v%0d_mem_en", idx), 32'(mem_en), 32'd1);
        check($sformatf("v%0d_mem_we", idx), 32'(mem_we), 32'(v.exp_dm && v.dm_we));
        check($sformatf("v%0d_mem_addr", idx), 32'(mem_addr), 32'(v.exp_dm ? v.dm_addr : v.if_addr));
        if (v.exp_dm && v.dm_we) check($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.dm_wdata);
        if_req   = 1'b0;
        dm_req   = 1'b0;
        if_addr  = ~v.if_addr;
        dm_addr  = ~v.dm_addr;
        dm_wdata = ~v.dm_wdata;
        n   = 0;
        got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (if_rvalid || dm_rvalid) begin
                n   = i;
                got = 1'b1;
            end
        end
        check($sformatf("v%0d_rvalid_latency", idx), 32'(n), 32'(MEM_LAT + 1));
        if (got) begin
            check($sformatf("v%0d_dm_rvalid", idx), 32'(dm_rvalid), 32'(v.exp_dm));
            check($sformatf("v%0d_if_rvalid", idx), 32'(if_rvalid), 32'(!v.exp_dm));
            check($sformatf("v%0d_rdata", idx), v.exp_dm ? dm_rdata : if_rdata, v.exp_rdata);
            @(negedge clk);
            check($sformatf("v%0d_rdata_hold", idx), v.exp_dm ? dm_rdata : if_rdata, v.exp_rdata);
            check($sformatf("v%0d_rvalid_pulse", idx), 32'(if_rvalid || dm_rvalid), 32'd0);
        end
    endtask

    vec_t vecs [10];
    vec_t v_extra;

    initial begin
        int n;
        int g;
        int gap;
        int busy_drops;
        bit got;

        vecs[0] = '{1'b1, 10'h005, 1'b0, 1'b0, 10'h000, 32'h0,         1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h010, 32'h12345678,  1'b1, 32'h00000000};
        vecs[2] = '{1'b1, 10'h010, 1'b0, 1'b0, 10'h000, 32'h0,         1'b0, 32'h12345678};
        vecs[3] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h005, 32'h0,         1'b1, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 10'h020, 1'b1, 1'b0, 10'h021, 32'h0,         1'b1, 32'hCAFEF00D};
        vecs[5] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h3FF, 32'hAAAA5555,  1'b1, 32'h00000000};
        vecs[6] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h3FF, 32'h0,         1'b1, 32'hAAAA5555};
        vecs[7] = '{1'b1, 10'h020, 1'b0, 1'b0, 10'h000, 32'h0,         1'b0, 32'h0BADC0DE};
        vecs[8] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h000, 32'h00C0FFEE,  1'b1, 32'h00000000};
        vecs[9] = '{1'b1, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0,         1'b0, 32'h00C0FFEE};

        // Reset held with both requests pending
        rst_n    = 1'b0;
        if_req   = 1'b1;
        if_addr  = 10'h005;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 10'h005;
        dm_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_outputs_%0d", i),
                  32'(|{if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
                        mem_en, mem_we, mem_addr, mem_wdata, busy}), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("first_issue_dm_gnt", 32'(dm_gnt), 32'd1);
        check("first_issue_if_gnt", 32'(if_gnt), 32'd0);
        if_req = 1'b0;
        dm_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = dm_rvalid;
        end
        check("first_load_rvalid", 32'(got), 32'd1);
        check("first_load_rdata", dm_rdata, 32'hDEADBEEF);
        @(negedge clk);

        // Table-driven single transactions
        for (int i = 0; i < 10; i++) do_vec(vecs[i], i);

        // Starvation: both held, expect DM,DM,DM,DM,IF repeating at MEM_LAT+2 spacing
        if_req  = 1'b1;
        if_addr = 10'h005;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 10'h010;
        g = 0;
        gap = 0;
        busy_drops = 0;
        for (int c = 0; c < 200 && g < 10; c++) begin
            @(negedge clk);
            gap++;
            if (g > 0 && !busy) busy_drops++;
            if (if_gnt || dm_gnt) begin
                check($sformatf("starve_gnt%0d_if", g), 32'(if_gnt), 32'((g % 5) == 4));
                check($sformatf("starve_gnt%0d_dm", g), 32'(dm_gnt), 32'((g % 5) != 4));
                if (g > 0) check($sformatf("starve_gap%0d", g), 32'(gap), 32'(MEM_LAT + 2));
                gap = 0;
                g++;
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        check("starve_grant_count", 32'(g), 32'd10);
        check("starve_busy_drops", 32'(busy_drops), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = !busy;
        end
        check("starve_return_idle", 32'(got), 32'd1);
`ifdef ARB_STATS_EN
        check("stat_dm_gnts", 32'(stat_dm_gnts), 32'd8 + 32'd1 + 32'd6);
        check("stat_if_gnts", 32'(stat_if_gnts), 32'd2 + 32'd4);
        check("stat_conflicts", 32'(stat_conflicts), 32'd10 + 32'd2);
`endif

        // Reset pulse during WAIT of a load discards it
        rst_n   = 1'b1;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 10'h005;
        @(negedge clk);
        check("midrst_dm_gnt", 32'(dm_gnt), 32'd1);
        dm_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_dm_rdata", dm_rdata, 32'd0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if_rvalid || dm_rvalid) n++;
        end
        check("midrst_no_rvalid", 32'(n), 32'd0);
        v_extra = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h010, 32'h0, 1'b1, 32'h12345678};
        do_vec(v_extra, 10);
        v_extra = '{1'b1, 10'h3FF, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 32'hAAAA5555};
        do_vec(v_extra, 11);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
